// File: rtl/ascii_seg_pkg.sv
// Shared types and character/glyph constants for the ASCII seven-segment scan display.
package ascii_seg_pkg;

  typedef logic [6:0] glyph_t;

  localparam glyph_t     SEG_BLANK  = 7'b1111111;
  localparam glyph_t     SEG_DASH   = 7'b0111111;
  localparam logic [7:0] CHAR_SPACE = 8'd32;
  localparam logic [7:0] CHAR_BS    = 8'd8;
  localparam logic [7:0] CHAR_MIN   = 8'd32;
  localparam logic [7:0] CHAR_MAX   = 8'd126;
  localparam logic [7:0] COUNT_MAX  = 8'd255;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= CHAR_MIN) && (ch <= CHAR_MAX);
  endfunction

endpackage

// File: rtl/ascii_glyph_decode.sv
// Combinational ASCII byte to active-low gfedcba glyph decoder.
// Define ASCII_SEG_CASEFOLD_EN to render uppercase 'A'..'R' with the lowercase glyphs.
module ascii_glyph_decode
  import ascii_seg_pkg::*;
(
  input  logic [7:0] ch,
  output logic [6:0] glyph_c
);

  logic [7:0] folded_c;

`ifdef ASCII_SEG_CASEFOLD_EN
  assign folded_c = ((ch >= 8'd65) && (ch <= 8'd82)) ? ch + 8'd32 : ch;
`else
  assign folded_c = ch;
`endif

  always_comb begin
    glyph_c = SEG_DASH;
    case (folded_c)
      8'd32:  glyph_c = SEG_BLANK;
      8'd48:  glyph_c = 7'b1000000;
      8'd49:  glyph_c = 7'b1111001;
      8'd50:  glyph_c = 7'b0100100;
      8'd51:  glyph_c = 7'b0110000;
      8'd52:  glyph_c = 7'b0011001;
      8'd53:  glyph_c = 7'b0010010;
      8'd54:  glyph_c = 7'b0000010;
      8'd55:  glyph_c = 7'b1111000;
      8'd56:  glyph_c = 7'b0000000;
      8'd57:  glyph_c = 7'b0010000;
      8'd97:  glyph_c = 7'b0100000;
      8'd98:  glyph_c = 7'b0000011;
      8'd99:  glyph_c = 7'b0100111;
      8'd100: glyph_c = 7'b0100001;
      8'd101: glyph_c = 7'b0000100;
      8'd102: glyph_c = 7'b0001110;
      8'd103: glyph_c = 7'b0010000;
      8'd104: glyph_c = 7'b0001011;
      8'd105: glyph_c = 7'b1101111;
      8'd106: glyph_c = 7'b1110011;
      8'd107: glyph_c = 7'b0001010;
      8'd108: glyph_c = 7'b1001111;
      8'd109: glyph_c = 7'b1101011;
      8'd110: glyph_c = 7'b0101011;
      8'd111: glyph_c = 7'b0100011;
      8'd112: glyph_c = 7'b0001100;
      8'd113: glyph_c = 7'b0011000;
      8'd114: glyph_c = 7'b0101111;
      default: glyph_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ascii_seg_scan_display.sv
// Scrolling multi-digit ASCII display: character buffer fed from the UART receiver,
// time-multiplexed common-anode scan. Glyph casefolding is set by ASCII_SEG_CASEFOLD_EN.
module ascii_seg_scan_display
  import ascii_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic [7:0]            char_count
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][7:0] buffer;
  logic [CNT_W-1:0]           scan_cnt;
  logic [IDX_W-1:0]           idx;
  glyph_t                     glyph_c;

  ascii_glyph_decode u_decode (
    .ch      (buffer[idx]),
    .glyph_c (glyph_c)
  );

  // Character buffer and accepted-character count; clear outranks a same-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer     <= {NUM_DIGITS{CHAR_SPACE}};
      char_count <= 8'd0;
    end else if (clear) begin
      buffer     <= {NUM_DIGITS{CHAR_SPACE}};
      char_count <= 8'd0;
    end else if (rx_valid) begin
      if (is_printable(rx_data)) begin
        buffer <= {buffer[NUM_DIGITS-2:0], rx_data};
        if (char_count != COUNT_MAX) begin
          char_count <= char_count + 8'd1;
        end
      end else if (rx_data == CHAR_BS) begin
        buffer <= {CHAR_SPACE, buffer[NUM_DIGITS-1:1]};
        if (char_count != 8'd0) begin
          char_count <= char_count - 8'd1;
        end
      end
    end
  end

  // Digit scan: seg and an are loaded together from the digit currently indexed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg      <= SEG_BLANK;
      an       <= '1;
    end else begin
      seg <= glyph_c;
      an  <= ~(NUM_DIGITS'(1) << idx);
      if (scan_cnt == CNT_LAST) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_ascii_seg_scan_display.sv
// Self-checking bench for ascii_seg_scan_display (NUM_DIGITS=4, SCAN_DIV=4) against a behavioural model.
module tb_ascii_seg_scan_display;

  localparam int ND   = 4;
  localparam int SCAN = 4;

  localparam logic [6:0] DIG_T [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] LET_T [18] = '{
    7'b0100000, 7'b0000011, 7'b0100111, 7'b0100001, 7'b0000100, 7'b0001110,
    7'b0010000, 7'b0001011, 7'b1101111, 7'b1110011, 7'b0001010, 7'b1001111,
    7'b1101011, 7'b0101011, 7'b0100011, 7'b0001100, 7'b0011000, 7'b0101111};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       clear;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic [7:0] char_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_edges;
  int mcount;
  int mbuf [ND];
  logic [6:0] cap [ND];

  ascii_seg_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SCAN)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .clear      (clear),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .char_count (char_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input int c);
    int cc = c;
`ifdef ASCII_SEG_CASEFOLD_EN
    if (cc >= 65 && cc <= 82) cc = cc + 32;
`endif
    if (cc == 32) return 7'b1111111;
    if (cc >= 48 && cc <= 57) return DIG_T[cc-48];
    if (cc >= 97 && cc <= 114) return LET_T[cc-97];
    return 7'b0111111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ND; k++) mbuf[k] = 32;
    mcount  = 0;
    n_edges = 0;
  endtask

  // Apply one clock edge's worth of input to the model.
  task automatic model_apply();
    int d;
    d = int'(rx_data);
    if (clear) begin
      for (int k = 0; k < ND; k++) mbuf[k] = 32;
      mcount = 0;
    end else if (rx_valid) begin
      if (d >= 32 && d <= 126) begin
        for (int k = ND - 1; k > 0; k--) mbuf[k] = mbuf[k-1];
        mbuf[0] = d;
        mcount  = (mcount < 255) ? mcount + 1 : 255;
      end else if (d == 8) begin
        for (int k = 0; k < ND - 1; k++) mbuf[k] = mbuf[k+1];
        mbuf[ND-1] = 32;
        mcount     = (mcount > 0) ? mcount - 1 : 0;
      end
    end
  endtask

  // One clock with full output check; strobes are dropped after the edge.
  task automatic tick();
    int         old_buf [ND];
    int         digit;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    old_buf = mbuf;
    @(posedge clk);
    n_edges++;
    model_apply();
    digit   = ((n_edges - 1) / SCAN) % ND;
    exp_seg = ref_glyph(old_buf[digit]);
    exp_an  = ~(4'b0001 << digit);
    @(negedge clk);
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("an", 32'(an), 32'(exp_an));
    chk("char_count", 32'(char_count), 32'(mcount));
    for (int k = 0; k < ND; k++) if (an[k] == 1'b0) cap[k] = seg;
    rx_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic send(input int c);
    rx_data  = 8'(c);
    rx_valid = 1'b1;
    tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(int'(s[i]));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
  endtask

  task automatic refresh();
    repeat (ND * SCAN) tick();
  endtask

  initial begin
    int r;
    rst      = 1'b1;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    clear    = 1'b0;
    for (int k = 0; k < ND; k++) cap[k] = 7'h00;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_count", 32'(char_count), 32'h0);
    rst = 1'b0;
    model_reset();

    // Idle scan after reset: first edge lights digit 0.
    tick();
    chk("first_an", 32'(an), 32'hE);
    repeat (ND * SCAN - 1) tick();

    send_str("1234");
    refresh();
    chk("d0_4", 32'(cap[0]), 32'h19);
    chk("d3_1", 32'(cap[3]), 32'h79);
    chk("cnt4", 32'(char_count), 32'd4);
    send(53);
    refresh();
    chk("d3_2", 32'(cap[3]), 32'h24);
    chk("d0_5", 32'(cap[0]), 32'h12);

    // Backspace handling and count floor.
    send(8);
    refresh();
    chk("bs_d3", 32'(cap[3]), 32'h7F);
    chk("bs_d2", 32'(cap[2]), 32'h24);
    chk("bs_d0", 32'(cap[0]), 32'h19);
    chk("bs_cnt", 32'(char_count), 32'd4);
    send(8);
    send(8);
    send(8);
    chk("cnt1", 32'(char_count), 32'd1);
    repeat (5) send(8);
    chk("cnt_floor", 32'(char_count), 32'd0);

    // Clear outranks a simultaneous strobe.
    send_str("89");
    rx_data  = 8'd55;
    rx_valid = 1'b1;
    clear    = 1'b1;
    tick();
    refresh();
    for (int k = 0; k < ND; k++) chk("clr_blank", 32'(cap[k]), 32'h7F);
    chk("clr_cnt", 32'(char_count), 32'd0);

    // Uppercase letter and an ignored control byte.
    send(65);
    refresh();
`ifdef ASCII_SEG_CASEFOLD_EN
    chk("upper_A", 32'(cap[0]), 32'h20);
`else
    chk("upper_A", 32'(cap[0]), 32'h3F);
`endif
    send(9);
    chk("ignore9", 32'(char_count), 32'd1);

    // Randomized traffic, including back-to-back strobes.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        rx_data  = 8'($urandom_range(0, 255));
        rx_valid = 1'($urandom_range(0, 1));
        do_clear();
      end else if (r < 55) send(int'($urandom_range(32, 126)));
      else if (r < 70) send(8);
      else if (r < 80) send(int'($urandom_range(0, 255)));
      else tick();
    end

    // Count saturation.
    do_clear();
    for (int i = 0; i < 256; i++) send(int'($urandom_range(32, 126)));
    chk("sat255", 32'(char_count), 32'd255);
    send(48);
    chk("sat_hold", 32'(char_count), 32'd255);
    refresh();

    // Asynchronous reset mid-digit.
    repeat (SCAN + 1) tick();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_cnt", 32'(char_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    refresh();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ascii_seg_scan_display.md
# ascii_seg_scan_display

Multi-digit, time-multiplexed ASCII-to-seven-segment display driver for the UART receive path. Each accepted received byte shifts into a character buffer, with the newest character entering the rightmost digit. The block decodes each character to an active-low glyph and scans the common-anode digits in rotation, one digit per `SCAN_DIV` cycles. It sits between the UART receiver output and the board display pins, and adds multi-digit scrolling, backspace and clear behaviour.

## Interface
- `NUM_DIGITS`, default 4: number of digits and width of `an`; legal range 2–8.
- `SCAN_DIV`, default 100000: clock cycles each digit stays lit; must be ≥ 2.
- `clk` input 1: single clock for the block.
- `rst` input 1: reset, asynchronous assert, active-high.
- `rx_data` input 8: received ASCII byte.
- `rx_valid` input 1: single-cycle strobe that qualifies `rx_data`. The block is always ready and has no backpressure.
- `clear` input 1: synchronous clear of buffer and count.
- `seg` output 7: glyph for the active digit, active-low, bit order `gfedcba`.
- `an` output NUM_DIGITS: digit enables, active-low. Bit 0 drives the rightmost digit.
- `dp` output 1: decimal point, active-low; tied high (off).
- `char_count` output 8: characters accepted since the last reset or clear; saturates at 255.

## Operation
- Buffer: `NUM_DIGITS` × 8-bit registers. Digit 0 is the rightmost.
- Cycle priority, highest first: `rst`, then `clear`, then `rx_valid`.
- Printable byte (32–126) accepted on `rx_valid`:
  - Digit k takes the value of digit k-1; digit 0 takes `rx_data`.
  - The top digit's old character is discarded.
  - `char_count` increments, saturating at 255.
- Backspace (8'd8) on `rx_valid`:
  - Digit k takes the value of digit k+1; the top digit becomes space (8'd32).
  - `char_count` decrements, saturating at 0.
- Any other byte (0–7, 9–31, 127–255): ignored; buffer and count unchanged.
- `clear`: every digit becomes space and `char_count` becomes 0. A simultaneous `rx_valid` is dropped.
- Glyph decode, active-low `gfedcba`:
  - '0'–'9' (48–57): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - 'a'–'r' (97–114): 0100000, 0000011, 0100111, 0100001, 0000100, 0001110, 0010000, 0001011, 1101111, 1110011, 0001010, 1001111, 1101011, 0101011, 0100011, 0001100, 0011000, 0101111.
  - Space (32): blank, 1111111.
  - Any other buffered character: dash, 0111111.
- Scan state:
  - Counter `scan_cnt` runs 0…SCAN_DIV-1. On wrap, digit index `idx` advances; `idx` wraps from NUM_DIGITS-1 to 0.
  - `an` drives a one-cold pattern at bit `idx`.
  - `seg` shows the decode of `buffer[idx]`.

## Timing
- Reset values:
  - Buffer all 8'd32; `char_count` 0; `scan_cnt` 0; `idx` 0.
  - `seg` 1111111; `an` all ones; `dp` 1.
- `seg` and `an` are registered together and always change on the same edge.
- First digit lit at the first edge after reset deassertion: `an` 1…110.
- Write latency: a byte strobed at edge N is in the buffer after edge N. If that digit is currently scanned, `seg` shows it after edge N+1.
- Each digit is active for exactly `SCAN_DIV` cycles. Full refresh period is `NUM_DIGITS` × `SCAN_DIV` cycles.
- Back-to-back `rx_valid` on every cycle is supported with no loss.
- Reset asserted mid-scan or mid-write takes immediate effect, independent of `clk`.

## Configuration
- `ASCII_SEG_CASEFOLD_EN` defined: uppercase 'A'–'R' (65–82) decode to the same glyph as the corresponding lowercase letter.
- `ASCII_SEG_CASEFOLD_EN` undefined: uppercase letters decode to dash.
- Buffer contents are identical in both builds; the raw byte is stored.

## Structure
- Package `ascii_seg_pkg` holds:
  - `glyph_t` (logic [6:0]).
  - Constants `SEG_BLANK`, `SEG_DASH`, `CHAR_SPACE` (8'd32), `CHAR_BS` (8'd8), `CHAR_MIN` (8'd32), `CHAR_MAX` (8'd126).
- Sub-module `ascii_glyph_decode`: combinational byte-to-`glyph_t` decoder. The casefold macro applies only inside this sub-module.
- Top level holds the buffer, counters and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4.
- Reset released with no input → `an` cycles 1110, 1101, 1011, 0111, 4 cycles each; `seg` = 1111111 throughout; `char_count` = 0.
- Write "1234" → digit0 = 0011001 ('4'), digit3 = 1111001 ('1'); `char_count` = 4. Then write '5' → digit3 = 0100100 ('2'), digit0 = 0010010.
- With buffer "2345", send 8'd8 → digits 3..0 = space, '2', '3', '4'; `char_count` decrements by 1. Send BS five times from count 1 → count stays 0.
- `clear` and `rx_valid`('7') in the same cycle → all digits blank; `char_count` = 0; '7' not stored.
- Send 'A' (65):
  - with the macro defined → glyph 0100000;
  - without it → 0111111.
  - Send 8'd9 → ignored, count unchanged.
- Send 256 printable bytes → `char_count` = 255. Assert `rst` mid-digit → `an` = 1111 and `seg` = 1111111 immediately, without waiting for `clk`.
